// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the two CPU ports, the arbiter and the QSPI
// memory controller. The arbiter uses the slave view; whoever drives the
// requests and models the controller uses the master view.
interface mem_arbiter_if #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int CMD_WIDTH      = 8
);
  // port 0 (instruction fetch)
  logic                      req_0;
  logic [CMD_WIDTH-1:0]      cmd_0;
  logic [DATA_BUS_WIDTH-1:0] wdata_0;
  logic                      done_0;
  logic [DATA_BUS_WIDTH-1:0] rdata_0;
  // port 1 (load/store)
  logic                      req_1;
  logic [CMD_WIDTH-1:0]      cmd_1;
  logic [DATA_BUS_WIDTH-1:0] wdata_1;
  logic                      done_1;
  logic [DATA_BUS_WIDTH-1:0] rdata_1;
  // memory controller side
  logic                      mem_op_valid;
  logic [CMD_WIDTH-1:0]      mem_cmd;
  logic [DATA_BUS_WIDTH-1:0] mem_wdata;
  logic                      mem_done;
  logic [DATA_BUS_WIDTH-1:0] mem_rdata;
  logic                      mem_abort;
  // status
  logic [1:0]                grant;
  logic                      timeout_err;
  logic                      err_clear;

  modport slave (
    input  req_0, cmd_0, wdata_0, req_1, cmd_1, wdata_1,
           mem_done, mem_rdata, err_clear,
    output done_0, rdata_0, done_1, rdata_1,
           mem_op_valid, mem_cmd, mem_wdata, mem_abort, grant, timeout_err
  );

  modport master (
    output req_0, cmd_0, wdata_0, req_1, cmd_1, wdata_1,
           mem_done, mem_rdata, err_clear,
    input  done_0, rdata_0, done_1, rdata_1,
           mem_op_valid, mem_cmd, mem_wdata, mem_abort, grant, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the single QSPI memory
// controller. One operation in flight at a time; the owner's command and
// write data are latched at grant, and a watchdog aborts an operation the
// controller never completes.
module mem_arbiter #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int CMD_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  // counter only ever needs to hold TIMEOUT_CYCLES-1
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;
  logic [CW-1:0]             wd_cnt_q, wd_cnt_d;
  logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_BUS_WIDTH-1:0] rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;
  logic                      done_0_q, done_0_d, done_1_q, done_1_d;
  logic                      abort_q, abort_d, terr_q, terr_d;
  logic                      op_valid, own1;
  logic [1:0]                grant;

  // arbitration and completion decode shared by the processes below
  logic pick0, pick1, owning, expire, finish;
  assign pick0  = bus.req_0 & (~bus.req_1 | last_grant_q);
  assign pick1  = bus.req_1 & (~bus.req_0 | ~last_grant_q);
  assign owning = (state_q != IDLE);
  assign own1   = (state_q == OWN1);
  // mem_done takes priority over an expiring watchdog
  assign expire = owning & ~bus.mem_done & (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign finish = owning & (bus.mem_done | expire);

  // state register plus all registered datapath/status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= '0;
      cmd_q        <= '0;
      wdata_q      <= '0;
      rdata_0_q    <= '0;
      rdata_1_q    <= '0;
      done_0_q     <= 1'b0;
      done_1_q     <= 1'b0;
      abort_q      <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      rdata_0_q    <= rdata_0_d;
      rdata_1_q    <= rdata_1_d;
      done_0_q     <= done_0_d;
      done_1_q     <= done_1_d;
      abort_q      <= abort_d;
      terr_q       <= terr_d;
    end
  end

  // next state: grant from IDLE, release on completion or watchdog expiry
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick0)      state_d = OWN0;
        else if (pick1) state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (finish) begin
          state_d      = IDLE;
          last_grant_d = own1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs, latches and watchdog
  always_comb begin
    cmd_d     = cmd_q;
    wdata_d   = wdata_q;
    rdata_0_d = rdata_0_q;
    rdata_1_d = rdata_1_q;
    wd_cnt_d  = wd_cnt_q;
    done_0_d  = finish & ~own1;
    done_1_d  = finish & own1;
    abort_d   = expire;
    // a new timeout beats a coincident clear
    terr_d    = expire | (terr_q & ~bus.err_clear);
    if (!owning) begin
      wd_cnt_d = '0;
      if (pick0) begin
        cmd_d   = bus.cmd_0;
        wdata_d = bus.wdata_0;
      end else if (pick1) begin
        cmd_d   = bus.cmd_1;
        wdata_d = bus.wdata_1;
      end
    end else if (bus.mem_done) begin
      // aborted operations leave rdata untouched
      if (own1) rdata_1_d = bus.mem_rdata;
      else      rdata_0_d = bus.mem_rdata;
    end else if (!expire) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end
  end

  // outputs decoded straight from the state register
  always_comb begin
    op_valid = owning;
    grant    = {state_q == OWN1, state_q == OWN0};
  end

  assign bus.mem_op_valid = op_valid;
  assign bus.grant        = grant;
  assign bus.mem_cmd      = cmd_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.rdata_0      = rdata_0_q;
  assign bus.rdata_1      = rdata_1_q;
  assign bus.done_0       = done_0_q;
  assign bus.done_1       = done_1_q;
  assign bus.mem_abort    = abort_q;
  assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both CPU ports and the
// memory controller. Inputs change and outputs are sampled 1ns after each
// rising edge.
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  mem_arbiter_if #(.DATA_BUS_WIDTH(8), .CMD_WIDTH(8)) bus ();

  mem_arbiter #(.DATA_BUS_WIDTH(8), .CMD_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.req_0 = 0; bus.req_1 = 0; bus.cmd_0 = 0; bus.cmd_1 = 0;
    bus.wdata_0 = 0; bus.wdata_1 = 0; bus.mem_done = 0; bus.mem_rdata = 0;
    bus.err_clear = 0;
    reset = 1;
    step(); step();
    reset = 0;
    total++; if (bus.grant !== 2'b00) $display("FAIL reset_grant got %b want 00", bus.grant); else passed++;
    total++; if (bus.mem_op_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.mem_op_valid); else passed++;
    total++; if ({bus.done_0, bus.done_1, bus.mem_abort, bus.timeout_err} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {bus.done_0, bus.done_1, bus.mem_abort, bus.timeout_err}); else passed++;
    total++; if ({bus.mem_cmd, bus.mem_wdata, bus.rdata_0, bus.rdata_1} !== 32'h0)
      $display("FAIL reset_data got %h want 0", {bus.mem_cmd, bus.mem_wdata, bus.rdata_0, bus.rdata_1}); else passed++;
  endtask

  task automatic test_single();
    int d0 = 0;
    int d1 = 0;
    bus.cmd_0 = 8'h3A; bus.wdata_0 = 8'h55; bus.req_0 = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.grant !== 2'b01 || bus.mem_cmd !== 8'h3A || bus.mem_op_valid !== 1'b1)
        $display("FAIL single_own[%0d] got grant=%b cmd=%h valid=%b want 01 3a 1", i, bus.grant, bus.mem_cmd, bus.mem_op_valid); else passed++;
      d0 += bus.done_0; d1 += bus.done_1;
      if (i == 4) begin bus.mem_done = 1; bus.mem_rdata = 8'hC3; end
      step();
    end
    bus.mem_done = 0; bus.mem_rdata = 8'h00; bus.req_0 = 0;
    d0 += bus.done_0; d1 += bus.done_1;
    total++; if (bus.done_0 !== 1'b1 || bus.rdata_0 !== 8'hC3)
      $display("FAIL single_done got done_0=%b rdata_0=%h want 1 c3", bus.done_0, bus.rdata_0); else passed++;
    total++; if (bus.grant !== 2'b00 || bus.mem_op_valid !== 1'b0 || bus.mem_wdata !== 8'h55)
      $display("FAIL single_release got grant=%b valid=%b wdata=%h want 00 0 55", bus.grant, bus.mem_op_valid, bus.mem_wdata); else passed++;
    step();
    d0 += bus.done_0; d1 += bus.done_1;
    total++; if (d0 != 1 || d1 != 0 || bus.rdata_0 !== 8'hC3 || bus.mem_cmd !== 8'h3A)
      $display("FAIL single_pulses got d0=%0d d1=%0d rdata_0=%h cmd=%h want 1 0 c3 3a", d0, d1, bus.rdata_0, bus.mem_cmd); else passed++;
  endtask

  task automatic test_tie();
    logic [1:0] g;
    bus.cmd_0 = 8'h10; bus.cmd_1 = 8'h21;
    bus.req_0 = 1; bus.req_1 = 1;
    reset = 1;
    step();
    reset = 0;
    total++; if (bus.grant !== 2'b00) $display("FAIL tie_postreset got %b want 00", bus.grant); else passed++;
    step();
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      for (int c = 0; c < 3; c++) begin
        total++; if (bus.grant !== g || bus.mem_cmd !== ((k % 2 == 0) ? 8'h10 : 8'h21))
          $display("FAIL tie_own[%0d.%0d] got grant=%b cmd=%h want %b", k, c, bus.grant, bus.mem_cmd, g); else passed++;
        if (c == 2) begin bus.mem_done = 1; bus.mem_rdata = 8'(8'hA0 + k); end
        step();
      end
      bus.mem_done = 0;
      total++; if (bus.grant !== 2'b00 || {bus.done_1, bus.done_0} !== g)
        $display("FAIL tie_idle[%0d] got grant=%b done=%b%b want 00 %b", k, bus.grant, bus.done_1, bus.done_0, g); else passed++;
      if (k == 3) begin bus.req_0 = 0; bus.req_1 = 0; end
      step();
    end
    total++; if (bus.grant !== 2'b00 || bus.rdata_0 !== 8'hA2 || bus.rdata_1 !== 8'hA3)
      $display("FAIL tie_end got grant=%b r0=%h r1=%h want 00 a2 a3", bus.grant, bus.rdata_0, bus.rdata_1); else passed++;
  endtask

  task automatic test_late();
    bus.cmd_0 = 8'h77; bus.req_0 = 1;
    step();
    bus.req_1 = 1; bus.cmd_1 = 8'h88; bus.cmd_0 = 8'h99;
    step();
    total++; if (bus.grant !== 2'b01 || bus.mem_cmd !== 8'h77)
      $display("FAIL late_hold got grant=%b cmd=%h want 01 77", bus.grant, bus.mem_cmd); else passed++;
    bus.mem_done = 1; bus.mem_rdata = 8'h5A;
    step();
    bus.mem_done = 0; bus.req_0 = 0;
    total++; if (bus.done_0 !== 1'b1 || bus.rdata_0 !== 8'h5A || bus.grant !== 2'b00)
      $display("FAIL late_done0 got done_0=%b r0=%h grant=%b want 1 5a 00", bus.done_0, bus.rdata_0, bus.grant); else passed++;
    step();
    total++; if (bus.grant !== 2'b10 || bus.mem_cmd !== 8'h88)
      $display("FAIL late_grant1 got grant=%b cmd=%h want 10 88", bus.grant, bus.mem_cmd); else passed++;
    bus.mem_done = 1; bus.mem_rdata = 8'hA5;
    step();
    bus.mem_done = 0; bus.req_1 = 0;
    total++; if (bus.done_1 !== 1'b1 || bus.done_0 !== 1'b0 || bus.rdata_1 !== 8'hA5)
      $display("FAIL late_done1 got done_1=%b done_0=%b r1=%h want 1 0 a5", bus.done_1, bus.done_0, bus.rdata_1); else passed++;
    step();
  endtask

  task automatic test_watchdog();
    bus.cmd_0 = 8'h01; bus.req_0 = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.grant !== 2'b01 || bus.mem_abort !== 1'b0 || bus.done_0 !== 1'b0)
        $display("FAIL wd_own[%0d] got grant=%b abort=%b done_0=%b want 01 0 0", i, bus.grant, bus.mem_abort, bus.done_0); else passed++;
      step();
    end
    bus.req_0 = 0;
    total++; if (bus.mem_abort !== 1'b1 || bus.done_0 !== 1'b1 || bus.timeout_err !== 1'b1)
      $display("FAIL wd_fire got abort=%b done_0=%b terr=%b want 1 1 1", bus.mem_abort, bus.done_0, bus.timeout_err); else passed++;
    total++; if (bus.grant !== 2'b00 || bus.rdata_0 !== 8'h5A)
      $display("FAIL wd_state got grant=%b r0=%h want 00 5a", bus.grant, bus.rdata_0); else passed++;
    step();
    total++; if (bus.mem_abort !== 1'b0 || bus.timeout_err !== 1'b1)
      $display("FAIL wd_sticky got abort=%b terr=%b want 0 1", bus.mem_abort, bus.timeout_err); else passed++;
    bus.err_clear = 1;
    step();
    bus.err_clear = 0;
    total++; if (bus.timeout_err !== 1'b0) $display("FAIL wd_clear got %b want 0", bus.timeout_err); else passed++;
  endtask

  task automatic test_coincident();
    bus.req_1 = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      total++; if (bus.grant !== 2'b10) $display("FAIL coin_own[%0d] got %b want 10", i, bus.grant); else passed++;
      if (i == 7) begin bus.mem_done = 1; bus.mem_rdata = 8'h3C; end
      step();
    end
    bus.mem_done = 0; bus.req_1 = 0;
    total++; if (bus.done_1 !== 1'b1 || bus.rdata_1 !== 8'h3C || bus.mem_abort !== 1'b0 || bus.timeout_err !== 1'b0)
      $display("FAIL coin_done got done_1=%b r1=%h abort=%b terr=%b want 1 3c 0 0", bus.done_1, bus.rdata_1, bus.mem_abort, bus.timeout_err); else passed++;
    // stray mem_done while idle must be ignored
    bus.mem_done = 1; bus.mem_rdata = 8'hEE;
    step();
    bus.mem_done = 0;
    total++; if ({bus.done_0, bus.done_1, bus.mem_abort} !== 3'b0 || bus.grant !== 2'b00 || bus.rdata_1 !== 8'h3C)
      $display("FAIL stray_done got d0=%b d1=%b abort=%b grant=%b r1=%h want 0 0 0 00 3c", bus.done_0, bus.done_1, bus.mem_abort, bus.grant, bus.rdata_1); else passed++;
  endtask

  task automatic test_reset_mid();
    // port 0 finishes last, so without reset a tie would go to port 1
    bus.req_0 = 1;
    step();
    bus.mem_done = 1; bus.mem_rdata = 8'h42;
    step();
    bus.mem_done = 0; bus.req_0 = 0;
    step();
    bus.req_1 = 1;
    step();
    step();
    total++; if (bus.grant !== 2'b10) $display("FAIL mid_own got %b want 10", bus.grant); else passed++;
    reset = 1;
    step();
    total++; if (bus.grant !== 2'b00 || bus.mem_op_valid !== 1'b0 || bus.done_1 !== 1'b0 || bus.rdata_0 !== 8'h00)
      $display("FAIL mid_reset got grant=%b valid=%b done_1=%b r0=%h want 00 0 0 00", bus.grant, bus.mem_op_valid, bus.done_1, bus.rdata_0); else passed++;
    reset = 0; bus.req_0 = 1; bus.req_1 = 1;
    step();
    total++; if (bus.grant !== 2'b01) $display("FAIL mid_tie got %b want 01", bus.grant); else passed++;
    bus.mem_done = 1;
    step();
    bus.mem_done = 0; bus.req_0 = 0; bus.req_1 = 0;
    total++; if (bus.done_0 !== 1'b1 || bus.done_1 !== 1'b0)
      $display("FAIL mid_done got done_0=%b done_1=%b want 1 0", bus.done_0, bus.done_1); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_late();
    test_watchdog();
    test_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single QSPI memory controller between the instruction-fetch path (port 0) and the load/store path (port 1). It sits between the CPU sequencer and the memory controller. It accepts one request per port, latches the winning command and write data, holds the controller's request line until the controller reports completion, and returns read data and a completion pulse to the owning port. A watchdog aborts any operation the controller fails to finish.

## Interface
Parameters:
- DATA_BUS_WIDTH, 8, width of write/read data.
- CMD_WIDTH, 8, width of the opaque command word. The arbiter forwards it and never decodes it.
- TIMEOUT_CYCLES, 1024, granted cycles without mem_done before an abort; must be ≥2.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- req_0 / req_1  in  1  request from port 0 / port 1; held high until that port's done.
- cmd_0 / cmd_1  in  CMD_WIDTH  command for each port; sampled at grant.
- wdata_0 / wdata_1  in  DATA_BUS_WIDTH  write data for each port; sampled at grant.
- done_0 / done_1  out  1  one-cycle completion pulse to the owning port.
- rdata_0 / rdata_1  out  DATA_BUS_WIDTH  read data for each port; valid with done and held until that port's next done.
- mem_op_valid  out  1  request to the memory controller.
- mem_cmd  out  CMD_WIDTH  latched command.
- mem_wdata  out  DATA_BUS_WIDTH  latched write data.
- mem_done  in  1  completion from the controller (its op_done_out).
- mem_rdata  in  DATA_BUS_WIDTH  read data from the controller; valid when mem_done is high.
- mem_abort  out  1  one-cycle pulse when the watchdog fires.
- grant  out  2  one-hot owner: 2'b01 = port 0, 2'b10 = port 1, 2'b00 = idle.
- timeout_err  out  1  sticky watchdog flag.
- err_clear  in  1  clears timeout_err.

## Operation
- The state machine has three states: IDLE, OWN0, OWN1. Reset enters IDLE.
- **IDLE, one request:** if only one req is high, go to that port's OWN state. Latch its cmd and wdata into mem_cmd and mem_wdata. Set grant. Clear the watchdog counter.
- **IDLE, both requests:** choose the port that is not last_grant. last_grant resets to 1, so port 0 wins the first tie.
- **OWNx:** mem_op_valid = 1. The arbiter ignores the other port's req and any change on cmd/wdata. Deasserting req_x does not cancel the operation.
- **OWNx with mem_done = 1:** register rdata_x ← mem_rdata and pulse done_x. Set last_grant ← x and return to IDLE; grant and mem_op_valid go low.
- **OWNx, watchdog:** the counter increments every OWN cycle in which mem_done = 0. When it reaches TIMEOUT_CYCLES−1:
  - pulse mem_abort and done_x; set timeout_err;
  - leave rdata_x unchanged; set last_grant ← x; return to IDLE.
- If mem_done and watchdog expiry occur in the same cycle, mem_done wins: normal completion, no error.
- timeout_err clears on err_clear or reset. If err_clear and a new timeout coincide, the set wins.
- mem_cmd and mem_wdata hold their last latched values while in IDLE.

## Timing
- **Reset values:** all outputs 0. State IDLE, last_grant = 1, counter = 0.
- **Grant latency:** req sampled high at edge n gives grant and mem_op_valid high from edge n (registered), i.e. they are visible in cycle n+1.
- **Completion latency:** mem_done sampled high at edge m gives done_x and rdata_x valid in cycle m+1. mem_op_valid is low in cycle m+1.
- **Minimum spacing:** at least one IDLE cycle separates operations. A held request is re-granted at the edge after the done pulse. Peak throughput is one operation per (controller latency + 2) cycles.
- **Stray mem_done:** mem_done in IDLE is ignored.
- **Reset mid-operation:** next cycle is IDLE with all outputs 0 and no done pulse. The controller shares this reset.

## Test plan
- **Single request:** port 0 only, cmd_0=8'h3A, wdata_0=8'h55; controller returns mem_done with mem_rdata=8'hC3 after 5 cycles.
  → grant=01 and mem_cmd=3A for 5 cycles; done_0 pulses once; rdata_0=C3; done_1 stays 0.
- **Tie then alternation:** req_0 and req_1 both held high from reset; controller completes each operation in 3 cycles.
  → grants go 01, 10, 01, 10, with exactly one IDLE cycle between them.
- **Late request:** req_1 rises while port 0 owns the controller.
  → port 1 waits; port 0's cmd is unchanged; port 1 is granted at the edge after done_0.
- **Watchdog:** TIMEOUT_CYCLES=8, mem_done never asserted.
  → mem_abort and done_0 pulse on the 8th OWN cycle; timeout_err=1; rdata_0 unchanged; err_clear drops timeout_err.
- **Coincident done and timeout:** mem_done arrives on the expiry cycle.
  → normal done, timeout_err stays 0, mem_abort stays 0.
- **Reset mid-operation:** reset asserted in the 2nd OWN1 cycle.
  → the following cycle has grant=00, mem_op_valid=0, no done_1; a later tie grants port 0 first.
